// File: rtl/queue_ram_arbiter.sv
// queue_ram_arbiter: round-robin owner of the shared Queue_RAM.
// Three agents (min scanner, child scanner, queue writer) take turns owning
// the RAM. A scan owns the read port for as long as its req is held. A write
// owns the write port for exactly one cycle. A dead TURN cycle separates
// owners so that stale registered read data never reaches the next owner.
// Queue occupancy is tracked here for the full/empty status.
module queue_ram_arbiter #(
  parameter int MAX_NODES = 100,
  parameter int ADDR_W    = 7,
  parameter int NODE_W    = 272
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              min_req,
  input  logic [ADDR_W-1:0] min_read_address,
  input  logic              child_req,
  input  logic [ADDR_W-1:0] child_read_address,
  input  logic              wr_req,
  input  logic [1:0]        wr_op,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic [NODE_W-1:0] wr_data,
  output logic              min_grant,
  output logic              child_grant,
  output logic              wr_ack,
  output logic              wr_error,
  output logic [ADDR_W-1:0] ram_read_address,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_write_address,
  output logic [NODE_W-1:0] ram_write_data,
  output logic [ADDR_W-1:0] node_count,
  output logic              queue_empty,
  output logic              queue_full
);

  typedef enum logic [2:0] {
    S_IDLE, S_OWN_MIN, S_OWN_CHILD, S_WRITE, S_TURN
  } state_t;

  typedef enum logic [1:0] {
    AG_MIN = 2'd0, AG_CHILD = 2'd1, AG_WR = 2'd2
  } agent_t;

  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_REMOVE = 2'b10;

  state_t            r_state;
  agent_t            r_last_owner;
  logic              r_min_grant;
  logic              r_child_grant;
  logic              r_wr_ack;
  logic              r_wr_error;
  logic              r_write_en;
  logic [1:0]        r_wr_op;
  logic [ADDR_W-1:0] r_node_count;

  logic              w_pick_valid;
  agent_t            w_pick;
  logic              w_queue_full;
  logic              w_insert_reject;

  assign w_queue_full    = (r_node_count == ADDR_W'(MAX_NODES));
  assign w_insert_reject = (wr_op == OP_INSERT) && w_queue_full;

  // Round-robin choice: first pending request after the last owner.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    w_pick_valid = 1'b0;
    w_pick       = AG_MIN;
    unique case (r_last_owner)
      AG_MIN: begin
        if (child_req)    begin w_pick_valid = 1'b1; w_pick = AG_CHILD; end
        else if (wr_req)  begin w_pick_valid = 1'b1; w_pick = AG_WR;    end
        else if (min_req) begin w_pick_valid = 1'b1; w_pick = AG_MIN;   end
      end
      AG_CHILD: begin
        if (wr_req)         begin w_pick_valid = 1'b1; w_pick = AG_WR;    end
        else if (min_req)   begin w_pick_valid = 1'b1; w_pick = AG_MIN;   end
        else if (child_req) begin w_pick_valid = 1'b1; w_pick = AG_CHILD; end
      end
      default: begin
        if (min_req)        begin w_pick_valid = 1'b1; w_pick = AG_MIN;   end
        else if (child_req) begin w_pick_valid = 1'b1; w_pick = AG_CHILD; end
        else if (wr_req)    begin w_pick_valid = 1'b1; w_pick = AG_WR;    end
      end
    endcase
  end

  // Ownership FSM with registered grant/ack/error/write-enable outputs.
  // TURN arbitrates like IDLE so owners are separated by exactly one dead cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state       <= S_IDLE;
      r_last_owner  <= AG_WR;
      r_min_grant   <= 1'b0;
      r_child_grant <= 1'b0;
      r_wr_ack      <= 1'b0;
      r_wr_error    <= 1'b0;
      r_write_en    <= 1'b0;
      r_wr_op       <= 2'b00;
    end else begin
      r_wr_ack   <= 1'b0;
      r_wr_error <= 1'b0;
      r_write_en <= 1'b0;
      unique case (r_state)
        S_OWN_MIN: begin
          if (!min_req) begin
            r_state     <= S_TURN;
            r_min_grant <= 1'b0;
          end
        end
        S_OWN_CHILD: begin
          if (!child_req) begin
            r_state       <= S_TURN;
            r_child_grant <= 1'b0;
          end
        end
        S_WRITE: begin
          r_state <= S_TURN;
        end
        default: begin
          if (w_pick_valid) begin
            r_last_owner <= w_pick;
            unique case (w_pick)
              AG_MIN: begin
                r_state     <= S_OWN_MIN;
                r_min_grant <= 1'b1;
              end
              AG_CHILD: begin
                r_state       <= S_OWN_CHILD;
                r_child_grant <= 1'b1;
              end
              default: begin
                r_state    <= S_WRITE;
                r_wr_ack   <= 1'b1;
                r_wr_error <= w_insert_reject;
                r_write_en <= !w_insert_reject;
                r_wr_op    <= wr_op;
              end
            endcase
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Occupancy counter, updated on the edge that ends the write cycle; never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_node_count <= '0;
    end else if (r_state == S_WRITE) begin
      if (r_wr_op == OP_INSERT && !r_wr_error) begin
        r_node_count <= r_node_count + ADDR_W'(1);
      end else if (r_wr_op == OP_REMOVE && r_node_count != '0) begin
        r_node_count <= r_node_count - ADDR_W'(1);
      end
    end
  end

  // Read address follows the current scanner owner, zero otherwise.
  always_comb begin
    ram_read_address = '0;
    if (r_state == S_OWN_MIN) begin
      ram_read_address = min_read_address;
    end else if (r_state == S_OWN_CHILD) begin
      ram_read_address = child_read_address;
    end
  end

  assign min_grant         = r_min_grant;
  assign child_grant       = r_child_grant;
  assign wr_ack            = r_wr_ack;
  assign wr_error          = r_wr_error;
  assign ram_write_enable  = r_write_en;
  assign ram_write_address = wr_address;
  assign ram_write_data    = wr_data;
  assign node_count        = r_node_count;
  assign queue_empty       = (r_node_count == '0);
  assign queue_full        = w_queue_full;

endmodule

// File: tb/tb_queue_ram_arbiter.sv
// Scoreboard bench for queue_ram_arbiter: stimulus pushes the expected
// ownership events, a negedge monitor pops and compares each one the DUT shows.
module tb_queue_ram_arbiter;

  localparam int ADDR_W = 7;
  localparam int NODE_W = 272;

  logic              clk;
  logic              reset;
  logic              min_req;
  logic [ADDR_W-1:0] min_read_address;
  logic              child_req;
  logic [ADDR_W-1:0] child_read_address;
  logic              wr_req;
  logic [1:0]        wr_op;
  logic [ADDR_W-1:0] wr_address;
  logic [NODE_W-1:0] wr_data;
  logic              min_grant;
  logic              child_grant;
  logic              wr_ack;
  logic              wr_error;
  logic [ADDR_W-1:0] ram_read_address;
  logic              ram_write_enable;
  logic [ADDR_W-1:0] ram_write_address;
  logic [NODE_W-1:0] ram_write_data;
  logic [ADDR_W-1:0] node_count;
  logic              queue_empty;
  logic              queue_full;

  queue_ram_arbiter #(.MAX_NODES(100), .ADDR_W(ADDR_W), .NODE_W(NODE_W)) dut (
    .clk                (clk),
    .reset              (reset),
    .min_req            (min_req),
    .min_read_address   (min_read_address),
    .child_req          (child_req),
    .child_read_address (child_read_address),
    .wr_req             (wr_req),
    .wr_op              (wr_op),
    .wr_address         (wr_address),
    .wr_data            (wr_data),
    .min_grant          (min_grant),
    .child_grant        (child_grant),
    .wr_ack             (wr_ack),
    .wr_error           (wr_error),
    .ram_read_address   (ram_read_address),
    .ram_write_enable   (ram_write_enable),
    .ram_write_address  (ram_write_address),
    .ram_write_data     (ram_write_data),
    .node_count         (node_count),
    .queue_empty        (queue_empty),
    .queue_full         (queue_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event kinds seen by the monitor.
  localparam logic [1:0] K_MIN = 2'd0, K_CHILD = 2'd1, K_WR = 2'd2;

  typedef struct {
    logic [1:0]        kind;
    logic [ADDR_W-1:0] addr;
    logic              err;
    logic              we;
    logic [NODE_W-1:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string name, input logic [NODE_W-1:0] act,
                       input logic [NODE_W-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [ADDR_W-1:0] addr,
                      input logic err, input logic we, input logic [NODE_W-1:0] data);
    exp_t e;
    e.kind = kind; e.addr = addr; e.err = err; e.we = we; e.data = data;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // One complete write transaction: request in IDLE, drop in WRITE, pass TURN.
  task automatic do_write(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                          input logic exp_err, input logic exp_we);
    logic [NODE_W-1:0] d;
    d = {8'hA5, 257'd0, a};
    push(K_WR, a, exp_err, exp_we, d);
    wr_op = op; wr_address = a; wr_data = d; wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    tick();
    tick();
  endtask

  // Monitor: pop one expectation per ownership event and compare it.
  always @(negedge clk) begin
    if (!wr_ack) check("we_outside_write", ram_write_enable, 1'b0);
    if (!min_grant && !child_grant) check("raddr_idle_zero", ram_read_address, '0);
    if (min_grant || child_grant || wr_ack) begin
      check("single_owner", $countones({min_grant, child_grant, wr_ack}), 1);
      if (q.size() == 0) begin
        check("unexpected_event", q.size(), 1);
      end else begin
        mon_e = q.pop_front();
        check("event_kind", wr_ack ? K_WR : (child_grant ? K_CHILD : K_MIN), mon_e.kind);
        if (wr_ack) begin
          check("wr_error", wr_error, mon_e.err);
          check("wr_enable", ram_write_enable, mon_e.we);
          check("wr_address", ram_write_address, mon_e.addr);
          check("wr_data", ram_write_data, mon_e.data);
        end else begin
          check("read_address", ram_read_address, mon_e.addr);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    min_req = 1'b0; child_req = 1'b0; wr_req = 1'b0;
    min_read_address = '0; child_read_address = '0;
    wr_op = 2'b00; wr_address = '0; wr_data = '0;
    tick();
    tick();
    check("rst_min_grant", min_grant, 1'b0);
    check("rst_child_grant", child_grant, 1'b0);
    check("rst_wr_ack", wr_ack, 1'b0);
    check("rst_wr_error", wr_error, 1'b0);
    check("rst_we", ram_write_enable, 1'b0);
    check("rst_raddr", ram_read_address, '0);
    check("rst_count", node_count, '0);
    check("rst_empty", queue_empty, 1'b1);
    check("rst_full", queue_full, 1'b0);
    reset = 1'b0;

    // Single scan over addresses 0..5.
    min_req = 1'b1; min_read_address = '0;
    tick();
    check("scan_grant_latency", min_grant, 1'b1);
    for (int i = 0; i < 6; i++) begin
      min_read_address = ADDR_W'(i);
      push(K_MIN, ADDR_W'(i), 1'b0, 1'b0, '0);
      if (i == 5) min_req = 1'b0;
      tick();
    end
    check("scan_release_grant", min_grant, 1'b0);
    tick();
    check("scan_idle_grant", min_grant, 1'b0);

    // Contention after reset: min, then child, then writer.
    pulse_reset();
    min_read_address = 7'd10; child_read_address = 7'd20;
    wr_op = 2'b01; wr_address = 7'd77; wr_data = 272'hABCD;
    push(K_MIN, 7'd10, 1'b0, 1'b0, '0);
    push(K_MIN, 7'd11, 1'b0, 1'b0, '0);
    push(K_CHILD, 7'd20, 1'b0, 1'b0, '0);
    push(K_CHILD, 7'd21, 1'b0, 1'b0, '0);
    push(K_WR, 7'd77, 1'b0, 1'b1, 272'hABCD);
    min_req = 1'b1; child_req = 1'b1; wr_req = 1'b1;
    tick();
    check("cont_min_first", min_grant, 1'b1);
    tick();
    min_read_address = 7'd11; min_req = 1'b0;
    tick();
    check("cont_turn1_min", min_grant, 1'b0);
    check("cont_turn1_child", child_grant, 1'b0);
    tick();
    check("cont_child_second", child_grant, 1'b1);
    tick();
    child_read_address = 7'd21; child_req = 1'b0;
    tick();
    check("cont_turn2_child", child_grant, 1'b0);
    check("cont_turn2_ack", wr_ack, 1'b0);
    tick();
    check("cont_wr_third", wr_ack, 1'b1);
    wr_req = 1'b0;
    tick();
    check("cont_ack_single_pulse", wr_ack, 1'b0);
    check("cont_count_after_insert", node_count, 7'd1);
    tick();

    // Fairness: after a child ownership, min wins a tie with child.
    child_req = 1'b1; child_read_address = 7'd30;
    push(K_CHILD, 7'd30, 1'b0, 1'b0, '0);
    tick();
    child_req = 1'b0;
    tick();
    min_req = 1'b1; child_req = 1'b1;
    min_read_address = 7'd40; child_read_address = 7'd31;
    push(K_MIN, 7'd40, 1'b0, 1'b0, '0);
    push(K_CHILD, 7'd31, 1'b0, 1'b0, '0);
    tick();
    check("rr_min_after_child", min_grant, 1'b1);
    check("rr_child_waits", child_grant, 1'b0);
    min_req = 1'b0;
    tick();
    tick();
    check("rr_child_next", child_grant, 1'b1);
    child_req = 1'b0;
    tick();
    tick();

    // Occupancy: fill to 100, reject the 101st, then remove and update.
    pulse_reset();
    check("occ_count_after_reset", node_count, '0);
    for (int i = 0; i < 100; i++) do_write(2'b01, ADDR_W'(i), 1'b0, 1'b1);
    check("occ_count_full", node_count, 7'd100);
    check("occ_full_flag", queue_full, 1'b1);
    check("occ_not_empty", queue_empty, 1'b0);
    do_write(2'b01, 7'd100, 1'b1, 1'b0);
    check("occ_reject_count", node_count, 7'd100);
    do_write(2'b10, 7'd5, 1'b0, 1'b1);
    check("occ_remove_count", node_count, 7'd99);
    check("occ_remove_full", queue_full, 1'b0);
    do_write(2'b00, 7'd6, 1'b0, 1'b1);
    check("occ_update_count", node_count, 7'd99);

    // Remove while empty: write happens, count stays at zero.
    pulse_reset();
    do_write(2'b10, 7'd9, 1'b0, 1'b1);
    check("empty_remove_count", node_count, '0);
    check("empty_remove_flag", queue_empty, 1'b1);

    // Reset in the middle of a child scan.
    do_write(2'b01, 7'd1, 1'b0, 1'b1);
    check("midrst_count_before", node_count, 7'd1);
    child_req = 1'b1; child_read_address = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      child_read_address = ADDR_W'(i);
      push(K_CHILD, ADDR_W'(i), 1'b0, 1'b0, '0);
      if (i == 3) begin
        reset = 1'b1; min_req = 1'b1; min_read_address = 7'd50;
      end
      tick();
    end
    check("midrst_child_drop", child_grant, 1'b0);
    check("midrst_min_not_yet", min_grant, 1'b0);
    check("midrst_count_clear", node_count, '0);
    check("midrst_empty", queue_empty, 1'b1);
    reset = 1'b0; child_req = 1'b0;
    push(K_MIN, 7'd50, 1'b0, 1'b0, '0);
    tick();
    check("midrst_min_granted", min_grant, 1'b1);
    min_req = 1'b0;
    tick();
    tick();

    check("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/queue_ram_arbiter.md
# queue_ram_arbiter

Shares the single Queue_RAM instance (one read port, one write port, 1-cycle registered read) among the three agents of the pathfinding engine: the minimum-cost scanner, the child-lookup scanner, and the queue update writer driven by the Dijkstra sequencer. It grants exclusive RAM ownership round-robin and holds each grant for a whole scan or one write. It inserts a one-cycle turnaround between owners and tracks queue occupancy for full/empty status.

## Interface
- MAX_NODES, 100, queue depth; occupancy saturates here
- ADDR_W, 7, RAM address width
- NODE_W, 272, width of one packed node_info record
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock, and the reset is synchronous and active-high
- min_req  in  1  minimum scanner requests the read port; held for the whole scan
- min_read_address  in  ADDR_W  minimum scanner address
- child_req  in  1  child scanner requests the read port; held for the whole scan
- child_read_address  in  ADDR_W  child scanner address
- wr_req  in  1  writer requests one write; held until wr_ack
- wr_op  in  2  01 insert (count+1), 10 remove (count−1), 00/11 update (count unchanged)
- wr_address  in  ADDR_W  write address
- wr_data  in  NODE_W  record to write
- min_grant, child_grant  out  1  read port owned by that scanner
- wr_ack  out  1  one-cycle pulse: write performed or rejected
- wr_error  out  1  valid with wr_ack: insert rejected because queue full
- ram_read_address  out  ADDR_W  to Queue_RAM
- ram_write_enable  out  1  to Queue_RAM
- ram_write_address  out  ADDR_W  to Queue_RAM
- ram_write_data  out  NODE_W  to Queue_RAM
- node_count  out  ADDR_W  valid entries in the queue
- queue_empty, queue_full  out  1  node_count==0 / node_count==MAX_NODES

## Operation
- States: IDLE, OWN_MIN, OWN_CHILD, WRITE, TURN.
- IDLE: if any request is pending, pick the first pending one in round-robin order after last_owner (order min→child→wr). Go to OWN_MIN, OWN_CHILD or WRITE and set last_owner. Otherwise stay in IDLE.
- OWN_MIN/OWN_CHILD: the grant output is high. ram_read_address = that scanner's address, combinational from state. Stay while its req is high. On req low → TURN.
- WRITE: lasts exactly one cycle. ram_write_enable=1 unless wr_op=01 and queue_full. wr_ack=1. wr_error=1 if the insert was rejected. Then → TURN.
- TURN: one dead cycle with no grant and no write, so the stale registered read data drains. Then → IDLE.
- Outside OWN states ram_read_address=0. Outside WRITE, ram_write_enable=0.
- ram_write_address and ram_write_data pass through wr_address and wr_data at all times.
- node_count updates on the clock edge ending WRITE:
  - +1 on an accepted insert.
  - −1 on a remove if node_count>0; a remove at 0 writes but leaves the count at 0.
  - Unchanged on an update.
- Arithmetic is unsigned ADDR_W and never wraps.
- A requester dropping req while not granted is legal and has no effect.
- Scanners must not deassert req before their done.

## Timing
- Reset values:
  - state=IDLE, last_owner=wr (so min wins first), node_count=0.
  - All grants, wr_ack, wr_error, ram_write_enable = 0; ram_read_address=0.
  - queue_empty=1, queue_full=0.
- Grant latency:
  - A req sampled high in IDLE at edge N gives grant high during cycle N+1.
  - The first RAM read data for the owner's address appears in cycle N+2.
- Release:
  - req low at edge M gives grant low in cycle M+1 (TURN).
  - The earliest next grant is cycle M+2.
- Write: wr_req sampled in IDLE at edge N gives ram_write_enable and wr_ack in cycle N+1. The writer drops wr_req by edge N+2. A wr_req still high in TURN/IDLE is treated as a new request.
- Simultaneous requests: round-robin only; no requester waits more than two other ownerships.
- Reset mid-scan or mid-write: at the next edge, grants drop and any write is not performed. node_count clears; RAM contents are not cleared, and the sequencer must re-initialise them.

## Test plan
- Single scan: after reset, min_req=1 with address 0..5, then 0 → min_grant high 1 cycle after req, ram_read_address tracks 0..5. Grant drops 1 cycle after req falls; TURN follows.
- Contention: min_req, child_req and wr_req all rise together → order min, child, wr. Each owner is separated by exactly one TURN cycle; wr_ack pulses once.
- Round-robin fairness: after a child ownership, min and child request together → min granted.
- Occupancy: 100 inserts → node_count=100, queue_full=1. The 101st insert gives wr_ack=1, wr_error=1, ram_write_enable=0, count stays 100. One remove → 99, queue_full=0.
- Remove at empty: wr_op=10 with count 0 → write performed, wr_error=0, node_count stays 0, queue_empty=1.
- Reset mid-scan: child granted, reset pulsed at address 3 → next cycle child_grant=0, state IDLE, node_count=0. A min_req held high is granted 1 cycle after reset falls.
